// File: rtl/uart_tx_ctrl.sv
// rtl/uart_tx_ctrl.sv - UART transmit controller: frame build, load/shift strobes, baud and bit timing
// Optional parity generation is compiled in by defining UART_TX_PARITY_EN.
module uart_tx_ctrl #(
   parameter int DIV_W = 19
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             write,
   input  logic [7:0]       din,
   input  logic             eight,
   input  logic             pen,
   input  logic             ohel,
   input  logic [DIV_W-1:0] baud_div,
   output logic             tx_rdy,
   output logic             ld,
   output logic             sh,
   output logic [10:0]      d_out
);

   typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

   state_t           state, state_nxt;
   logic [DIV_W-1:0] baud_cnt;
   logic [DIV_W-1:0] baud_lim;
   logic [3:0]       bit_cnt;
   logic             last_bit;
   logic             bit9, bit10;
   logic [10:0]      frame;

`ifdef UART_TX_PARITY_EN
   logic par;
   assign par   = (eight ? ^din : ^din[6:0]) ^ ohel;
   assign bit9  = eight ? din[7] : (pen ? par : 1'b1);
   assign bit10 = eight ? (pen ? par : 1'b1) : 1'b1;
`else
   logic unused_parity_cfg;
   assign unused_parity_cfg = pen ^ ohel;
   assign bit9  = eight ? din[7] : 1'b1;
   assign bit10 = 1'b1;
`endif

   assign frame = {bit10, bit9, din[6:0], 1'b0, 1'b1};

   // A zero divisor behaves like one; >= keeps the counter bounded if the divisor shrinks mid-frame.
   assign baud_lim = (baud_div == '0) ? '0 : baud_div - 1'b1;
   assign tx_rdy   = (state == IDLE);
   assign ld       = (state == LOAD);
   assign sh       = (state == SEND) && (baud_cnt >= baud_lim);
   assign last_bit = (bit_cnt == 4'd10);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (write) state_nxt = LOAD;
         LOAD:    state_nxt = SEND;
         SEND:    if (sh && last_bit) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         d_out    <= 11'h7FF;
         baud_cnt <= '0;
         bit_cnt  <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               if (write) d_out <= frame;
            end
            LOAD: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
            end
            SEND: begin
               if (sh) begin
                  baud_cnt <= '0;
                  bit_cnt  <= last_bit ? 4'd0 : bit_cnt + 4'd1;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               baud_cnt <= '0;
               bit_cnt  <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb/tb_uart_tx_ctrl.sv - directed self-checking bench for uart_tx_ctrl
module tb_uart_tx_ctrl;

   localparam int DIV_W = 19;

   logic             clk = 1'b0;
   logic             rst;
   logic             write;
   logic [7:0]       din;
   logic             eight;
   logic             pen;
   logic             ohel;
   logic [DIV_W-1:0] baud_div;
   logic             tx_rdy;
   logic             ld;
   logic             sh;
   logic [10:0]      d_out;

   int n_checks = 0;
   int n_errors = 0;

   uart_tx_ctrl #(.DIV_W(DIV_W)) dut (
      .clk      (clk),
      .rst      (rst),
      .write    (write),
      .din      (din),
      .eight    (eight),
      .pen      (pen),
      .ohel     (ohel),
      .baud_div (baud_div),
      .tx_rdy   (tx_rdy),
      .ld       (ld),
      .sh       (sh),
      .d_out    (d_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Issues one write at a negedge, then follows the frame cycle by cycle.
   // wr2_at: issue a stray write after that many sh pulses; abort_at: assert rst after that many.
   task automatic run_frame(input string tag, input logic [7:0] d, input logic e, input logic p,
                            input logic o, input logic [DIV_W-1:0] div, input logic [10:0] exp_dout,
                            input int wr2_at, input int abort_at);
      int div_eff, cyc, last_ev, nsh, bad_gap, extra_ld;
      bit done, aborted;
      div_eff  = (div == 0) ? 1 : int'(div);
      baud_div = div;
      check({tag, "_rdy_pre"}, 32'(tx_rdy), 1);
      din = d; eight = e; pen = p; ohel = o; write = 1'b1;
      @(negedge clk);
      write = 1'b0;
      check({tag, "_ld"}, 32'(ld), 1);
      check({tag, "_rdy_busy"}, 32'(tx_rdy), 0);
      check({tag, "_sh_in_load"}, 32'(sh), 0);
      check({tag, "_dout"}, 32'(d_out), 32'(exp_dout));
      cyc = 0; last_ev = 0; nsh = 0; bad_gap = 0; extra_ld = 0; done = 0; aborted = 0;
      while (!done && cyc < 2000) begin
         @(negedge clk);
         cyc++;
         write = 1'b0;
         if (ld) extra_ld++;
         if (sh) begin
            nsh++;
            if (cyc - last_ev != div_eff) bad_gap++;
            last_ev = cyc;
            if (nsh == wr2_at) begin
               din = 8'h00; write = 1'b1;
            end
            if (nsh == abort_at) begin
               rst = 1'b1;
               #1;
               check({tag, "_abort_rdy"}, 32'(tx_rdy), 1);
               check({tag, "_abort_sh"}, 32'(sh), 0);
               check({tag, "_abort_dout"}, 32'(d_out), 32'h7FF);
               @(negedge clk);
               check({tag, "_abort_sh_held"}, 32'(sh), 0);
               rst = 1'b0;
               done = 1; aborted = 1;
            end
         end else if (tx_rdy) begin
            check({tag, "_sh_count"}, 32'(nsh), 11);
            check({tag, "_rdy_latency"}, 32'(cyc - last_ev), 1);
            done = 1;
         end
      end
      if (!done) check({tag, "_timeout"}, 0, 1);
      check({tag, "_gaps"}, 32'(bad_gap), 0);
      check({tag, "_extra_ld"}, 32'(extra_ld), 0);
      if (!aborted) check({tag, "_dout_hold"}, 32'(d_out), 32'(exp_dout));
   endtask

   initial begin
      int bad_idle;
      rst = 1'b1; write = 1'b0; din = 8'h00; eight = 1'b0; pen = 1'b0; ohel = 1'b0;
      baud_div = 19'd4;
      #12;
      check("rst_rdy", 32'(tx_rdy), 1);
      check("rst_ld", 32'(ld), 0);
      check("rst_sh", 32'(sh), 0);
      check("rst_dout", 32'(d_out), 32'h7FF);
      @(negedge clk);
      rst = 1'b0;

      bad_idle = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (tx_rdy !== 1'b1 || ld !== 1'b0 || sh !== 1'b0 || d_out !== 11'h7FF) bad_idle++;
      end
      check("idle_after_rst", 32'(bad_idle), 0);

      run_frame("f75", 8'h75, 1'b0, 1'b0, 1'b0, 19'd4, 11'h7D5, 0, 0);
`ifdef UART_TX_PARITY_EN
      run_frame("pa5_even", 8'hA5, 1'b1, 1'b1, 1'b0, 19'd3, 11'h295, 0, 0);
`else
      run_frame("pa5_even", 8'hA5, 1'b1, 1'b1, 1'b0, 19'd3, 11'h695, 0, 0);
`endif
      run_frame("pa5_odd", 8'hA5, 1'b1, 1'b1, 1'b1, 19'd3, 11'h695, 0, 0);
      run_frame("wr2", 8'h3C, 1'b1, 1'b0, 1'b0, 19'd2, 11'h4F1, 3, 0);
      run_frame("abort", 8'h55, 1'b0, 1'b0, 1'b0, 19'd4, 11'h755, 0, 5);
      run_frame("f41", 8'h41, 1'b0, 1'b0, 1'b0, 19'd4, 11'h705, 0, 0);
      run_frame("div0", 8'h55, 1'b0, 1'b0, 1'b0, 19'd0, 11'h755, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter: DIV_W, 19, width of baud divisor input.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 write  input  1  one-cycle transmit request from processor side.
REQ-005 din  input  8  character to transmit.
REQ-006 eight  input  1  1 = 8 data bits, 0 = 7 data bits.
REQ-007 pen  input  1  parity enable.
REQ-008 ohel  input  1  parity sense: 1 = odd, 0 = even.
REQ-009 baud_div  input  DIV_W  clk cycles per bit time.
REQ-010 tx_rdy  output  1  transmitter idle, new write accepted.
REQ-011 ld  output  1  one-cycle load strobe to downstream shift register.
REQ-012 sh  output  1  one-cycle bit-time-up shift strobe to downstream shift register.
REQ-013 d_out  output  11  frame for parallel load, LSB shifted first.

Function
REQ-014 States: IDLE, LOAD, SEND; IDLE->LOAD on write while tx_rdy=1; LOAD->SEND unconditionally after one cycle; SEND->IDLE after 11th sh.
REQ-015 write asserted in cycle N while IDLE: din/eight/pen/ohel captured at edge N, ld=1 for cycle N+1 only, tx_rdy=0 from cycle N+1.
REQ-016 write while not IDLE: ignored, no capture, d_out and counters unchanged.
REQ-017 Frame: d_out[0]=1 (idle), d_out[1]=0 (start), d_out[8:2]=data[6:0].
REQ-018 eight=1: d_out[9]=data[7]; d_out[10]=parity if pen=1, else 1.
REQ-019 eight=0: d_out[9]=parity if pen=1, else 1; d_out[10]=1.
REQ-020 Parity = XOR of used data bits (7 or 8), inverted when ohel=1.
REQ-021 d_out holds its captured value until next accepted write.
REQ-022 Baud counter clears on entering SEND, counts 0..baud_div-1; sh=1 in the cycle count equals baud_div-1, then counter wraps to 0.
REQ-023 baud_div=0 treated as 1 (sh every SEND cycle).
REQ-024 Bit counter clears at ld, increments per sh; at 11th sh state returns to IDLE and tx_rdy=1 in the following cycle.
REQ-025 sh and ld never asserted in the same cycle; sh never asserted in IDLE or LOAD.
REQ-026 baud_div sampled every cycle; changing it mid-frame is unsupported, but counter must not overrun (compare uses >=).

Reset
REQ-027 rst=1 forces immediately, independent of clk: state IDLE, tx_rdy=1, ld=0, sh=0, d_out=11'h7FF, all counters 0.
REQ-028 rst asserted mid-frame aborts frame; no further sh; first write after rst release starts a fresh frame.

Configuration
REQ-029 Macro UART_TX_PARITY_EN: defined -> parity per REQ-018..020; undefined -> pen and ohel ignored, parity logic absent, frame formed as if pen=0.

Verification
REQ-030 rst pulse, then idle 10 cycles -> tx_rdy=1, ld=0, sh=0, d_out=11'h7FF throughout.
REQ-031 baud_div=4, eight=0, pen=0, din=8'h75, write 1 cycle -> ld one cycle later, d_out=11'h7D5, 11 sh pulses exactly 4 cycles apart, tx_rdy=1 cycle after 11th sh.
REQ-032 UART_TX_PARITY_EN defined, eight=1, pen=1, ohel=0, din=8'hA5 -> d_out=11'h295; repeat with ohel=1 -> d_out=11'h695.
REQ-033 Second write (din=8'h00) issued after 3rd sh of a frame -> ignored, d_out unchanged, sh count still 11.
REQ-034 rst asserted after 5th sh -> tx_rdy=1 and sh=0 immediately; new write with din=8'h41, eight=0, pen=0 -> d_out=11'h705, full 11-sh frame.
REQ-035 baud_div=0, din=8'h55, eight=0, pen=0 -> sh asserted every SEND cycle, 11 consecutive cycles, then tx_rdy=1.
